// File: rtl/uart_rx.sv
// 8N1 UART receiver, OVERSAMPLE rx_enb ticks per bit; UART_RX_MAJORITY_EN selects 3-tick majority sampling.
// Latency: rx_valid/frame_err pulse one clk after the stop-bit sample tick (mid stop bit).
// Backpressure: none; rx_data is simply overwritten by each good frame, no overrun detection.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_enb,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic            rx_s1;
    logic            rx_s2;
    logic            rx_d;
    logic [TW-1:0]   tick;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            sample;
    logic            fall_edge;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall_edge = rx_d & ~rx_s2;

`ifdef UART_RX_MAJORITY_EN
    // Line values at the two previous rx_enb ticks; the current tick is rx_s2 itself.
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
        end else if (rx_enb) begin
            hist <= {hist[0], rx_s2};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s2) | (hist[0] & rx_s2);
`else
    assign sample = rx_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tick    <= '0;
                    bit_cnt <= 3'd0;
                    if (fall_edge) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (rx_enb) begin
                        if (tick == TICK_HALF) begin
                            tick    <= '0;
                            bit_cnt <= 3'd0;
                            if (sample) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rx_enb) begin
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            shreg <= {sample, shreg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (rx_enb) begin
                        if (tick == TICK_LAST) begin
                            tick    <= '0;
                            bit_cnt <= 3'd0;
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                            if (sample) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tick    <= '0;
                    bit_cnt <= 3'd0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized + directed bench for uart_rx: stimulus pushes expected frames, a monitor pops and compares.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_enb = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         enb_cnt = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] rbyte;
    logic       rok;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_enb    (rx_enb),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // rx_enb: one clk in every four, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            enb_cnt = (enb_cnt + 1) % 4;
            rx_enb  = (enb_cnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Hold the line at v for n oversample ticks.
    task automatic drive(input logic v, input int n);
        repeat (n) begin
            rx = v;
            @(posedge clk iff rx_enb);
            #1;
        end
    endtask

    // One 8N1 frame; glitch flips the line for the single tick at each data bit centre.
    task automatic send(input logic [7:0] b, input logic stop_ok, input bit glitch);
        if (stop_ok) begin
            exp_q.push_back('{is_err: 1'b0, data: b});
            last_good = b;
        end else begin
            exp_q.push_back('{is_err: 1'b1, data: last_good});
        end
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                drive(b[i], 7);
                drive(~b[i], 1);
                drive(b[i], 8);
            end else begin
                drive(b[i], 16);
            end
        end
        drive(stop_ok, 16);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every output pulse must match the next expected frame outcome.
    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err)) begin
            check("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual valid=%0b ferr=%0b data=%0h required no pulse",
                         rx_valid, frame_err, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", {24'd0, rx_data}, 0);
        check("reset_rx_valid", {31'd0, rx_valid}, 0);
        check("reset_rx_busy", {31'd0, rx_busy}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        rst = 1'b0;
        last_good = 8'h00;
        drive(1'b1, 20);

        // Single byte
        send(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 4);
        wait_empty("a5_done");
        check("a5_busy_after", {31'd0, rx_busy}, 0);

        // Back-to-back with a one-bit stop
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        drive(1'b1, 4);
        wait_empty("b2b_done");

        // False start: low for 4 ticks then high
        drive(1'b0, 3);
        check("false_start_busy", {31'd0, rx_busy}, 1);
        drive(1'b0, 1);
        drive(1'b1, 4);
        check("false_start_idle_by_tick8", {31'd0, rx_busy}, 0);
        drive(1'b1, 12);

        // Framing error followed by a long break
        send(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 40);
        check("break_busy", {31'd0, rx_busy}, 0);
        check("break_data_held", {24'd0, rx_data}, {24'd0, last_good});
        wait_empty("ferr_done");
        drive(1'b1, 16);
        send(8'h42, 1'b1, 1'b0);
        drive(1'b1, 4);
        wait_empty("after_break_done");

        // Reset in the middle of data bit 4 of 0x5A
        rbyte = 8'h5A;
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(rbyte[i], 16);
        drive(rbyte[4], 8);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_busy", {31'd0, rx_busy}, 0);
        check("midreset_data", {24'd0, rx_data}, 0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_good = 8'h00;
        drive(1'b1, 20);
        send(8'h81, 1'b1, 1'b0);
        drive(1'b1, 4);
        wait_empty("after_reset_done");

`ifdef UART_RX_MAJORITY_EN
        send(8'h96, 1'b1, 1'b1);
        drive(1'b1, 4);
        wait_empty("glitch_done");
`endif

        // Random frames, random stop quality and gaps
        for (int n = 0; n < 24; n++) begin
            rbyte = 8'($urandom_range(0, 255));
            rok   = ($urandom_range(0, 4) != 0);
            send(rbyte, rok, 1'b0);
            if (!rok) begin
                drive(1'b0, $urandom_range(0, 30));
                drive(1'b1, 1 + $urandom_range(0, 8));
            end else begin
                drive(1'b1, $urandom_range(0, 6));
            end
        end
        drive(1'b1, 4);
        wait_empty("random_done");
        check("final_busy", {31'd0, rx_busy}, 0);
        check("final_data", {24'd0, rx_data}, {24'd0, last_good});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning rx_enb ticks per bit; legal values are even, 8..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port rx_enb, input, 1, oversample tick, one clk wide, at OVERSAMPLE x baud.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data, output, 8, last correctly framed byte.
REQ-007 SHALL have port rx_valid, output, 1, one-clk pulse when rx_data is updated.
REQ-008 SHALL have port rx_busy, output, 1, high while a frame is being received.
REQ-009 SHALL have port frame_err, output, 1, one-clk pulse when the stop bit samples low.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; all references to the line mean the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA and STOP, with a tick counter (0..OVERSAMPLE-1) and a bit counter (0..7).
REQ-012 IDLE: on a falling edge of the line (previous high, current low), the block SHALL enter START with the tick counter at 0; the falling edge is checked every clk, independent of rx_enb.
REQ-013 Counters SHALL advance only on clk cycles where rx_enb=1; with no ticks, state and counters hold.
REQ-014 START: at tick count OVERSAMPLE/2-1 the block SHALL sample the line. If high, it SHALL treat the start as false and return to IDLE with no output pulse. If low, it SHALL enter DATA with the tick and bit counters at 0.
REQ-015 DATA: at tick count OVERSAMPLE-1 the block SHALL sample one bit and shift it into bit [7] of the shift register, shifting right so that the first bit lands in bit [0]. It SHALL enter STOP after bit counter 7; otherwise it SHALL increment the bit counter.
REQ-016 STOP: at tick count OVERSAMPLE-1 the block SHALL sample the stop bit.
  - If high: on the next clk, rx_data SHALL be loaded from the shift register and rx_valid SHALL be 1 for one clk.
  - If low: frame_err SHALL be 1 for one clk and rx_data SHALL be unchanged.
  - In both cases the block SHALL return to IDLE.
REQ-017 rx_busy SHALL be 1 in every state other than IDLE, and SHALL be registered.
REQ-018 A line held low after a frame error (break) SHALL NOT start a new frame until a fresh falling edge occurs.
REQ-019 rx_data SHALL hold its value indefinitely between rx_valid pulses; there is no handshake and no overrun detection.
REQ-020 rx_valid and frame_err SHALL never be 1 in the same clk.
REQ-021 The tick counter SHALL wrap from OVERSAMPLE-1 to 0 at every sample point.
REQ-022 Any undefined state encoding SHALL recover to IDLE on the next clk.

Reset
REQ-023 While rst=1 the block SHALL set state=IDLE, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, counters=0, shift register=0 and synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame without any output pulse; after rst falls, a new frame SHALL require a fresh falling edge.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN SHALL select the bit-sampling method.
  - Defined: each sample (start, data, stop) SHALL be the majority vote of the line at the three ticks ending at the sample point, i.e. tick counts N-2, N-1 and N, where N is the sample count.
  - Undefined: each sample SHALL be the single value of the line at the sample tick.
  - Timing and latency SHALL be identical in both builds.

Verification
REQ-026 OVERSAMPLE=16, rx_enb every 4th clk, send 0xA5 -> exactly one rx_valid, rx_data=8'hA5, frame_err never 1, rx_busy 0 after the frame.
REQ-027 Send 0x00 then 0xFF back-to-back with a one-bit-time stop bit -> two rx_valid pulses with data 00 then FF.
REQ-028 Line low for 4 ticks, then high -> no rx_valid, no frame_err, rx_busy returns to 0 by tick 8.
REQ-029 Send 0x3C with the stop bit low, then hold the line low for 40 ticks -> one frame_err, rx_data keeps its prior value, no further activity until the next falling edge.
REQ-030 Assert rst during data bit 4 of 0x5A, then send 0x81 -> no pulse for the aborted frame; rx_valid with rx_data=8'h81.
REQ-031 Run with UART_RX_MAJORITY_EN defined, injecting a single-tick glitch at every data sample point while sending 0x96 -> rx_data=8'h96.
